// File: rtl/fp_pkg.sv
// Shared definitions for the FMA read-out path: binary32 constants,
// flag bit positions, drain FSM states and a leading-one helper.
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'hFFC0_0000;
  localparam logic [31:0] FP_PINF    = 32'h7F80_0000;

  localparam int NX = 0;
  localparam int UF = 1;
  localparam int OF = 2;
  localparam int DZ = 3;
  localparam int NV = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } drain_st_e;

  // Index of the most significant set bit; 0 when v is zero.
  function automatic logic [4:0] lead_one(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i[4:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_pack.sv
// Combinational pack of a sign/magnitude/exponent triple into binary32
// with round-to-nearest-even, subnormal handling and overflow to infinity.
module fp32_pack
  import fp_pkg::*;
(
  input  logic               sign_i,
  input  logic [32:0]        mag_i,
  input  logic [4:0]         lead_i,
  input  logic signed [11:0] e_i,
  output logic [31:0]        rslt_o,
  output logic [4:0]         flag_o
);

  localparam logic signed [11:0] E_MAX = FP_EXP_MAX[11:0];
  localparam logic signed [11:0] E_TOP = E_MAX - 12'sd1;

  logic [32:0]        norm;
  logic [64:0]        sub;
  logic signed [11:0] neg_e;
  logic [5:0]         sub_sh;
  logic [22:0]        frac;
  logic [23:0]        sum;
  logic [7:0]         e_fld;
  logic               g, st, up, nx;

  always_comb begin
    // Leading one moved to bit 32; fraction sits in [31:9], guard at 8.
    norm   = mag_i << (6'd32 - {1'b0, lead_i});
    neg_e  = -e_i;
    // Subnormal denormalisation by (1 - E), expressed relative to norm[32:10].
    sub_sh = (neg_e > 12'sd33) ? 6'd33 : neg_e[5:0];
    sub    = {norm, 32'b0} >> sub_sh;

    if (e_i >= 12'sd1) begin
      frac  = norm[31:9];
      g     = norm[8];
      st    = |norm[7:0];
      e_fld = e_i[7:0];
    end else begin
      frac  = sub[64:42];
      g     = sub[41];
      st    = |sub[40:0];
      e_fld = 8'd0;
    end

    up  = g & (st | frac[0]);
    sum = {1'b0, frac} + {23'b0, up};
    nx  = g | st;

    rslt_o = '0;
    flag_o = '0;
    if (mag_i == '0) begin
      rslt_o = '0;
    end else if ((e_i >= E_MAX) || (sum[23] && (e_i == E_TOP))) begin
      rslt_o     = {sign_i, FP_PINF[30:0]};
      flag_o[OF] = 1'b1;
      flag_o[NX] = 1'b1;
    end else begin
      // A carry out of the fraction bumps the exponent field, which also
      // turns the largest subnormal into the minimum normal.
      rslt_o     = {sign_i, e_fld + {7'b0, sum[23]}, sum[22:0]};
      flag_o[NX] = nx;
      flag_o[UF] = nx & (e_i < 12'sd1);
    end
    flag_o[DZ] = 1'b0;
    flag_o[NV] = 1'b0;
  end

endmodule

// File: rtl/acc_drain_fp32.sv
// Snapshots four block-float accumulator lanes and streams them out as
// binary32 values, lane 0 first, through a stallable two-stage pipeline.
module acc_drain_fp32
  import fp_pkg::*;
#(
  parameter int EXP_BIAS = 127,
  parameter int LANES    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] acc0,
  input  logic signed [31:0] acc1,
  input  logic signed [31:0] acc2,
  input  logic signed [31:0] acc3,
  input  logic signed [9:0]  exp0,
  input  logic signed [9:0]  exp1,
  input  logic signed [9:0]  exp2,
  input  logic signed [9:0]  exp3,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         lane,
  output logic [31:0]        rslt,
  output logic [4:0]         flag,
  output logic               done
);

  localparam logic [1:0]         LAST  = 2'(LANES - 1);
  localparam logic signed [11:0] E_OFS = 12'(FP_BIAS - 30 - EXP_BIAS);

  drain_st_e          state_q, state_d;
  logic [1:0]         iss_q, iss_d;
  logic signed [31:0] acc_q [4];
  logic signed [9:0]  exp_q [4];
  logic               stall, accept, issue, snap;

  logic signed [31:0] acc_s;
  logic signed [9:0]  exp_s;
  logic [32:0]        mag_s;
  logic [4:0]         lead_s;
  logic signed [11:0] e_s;

  logic               vld_p1_q;
  logic               sign_p1_q;
  logic [32:0]        mag_p1_q;
  logic [4:0]         lead_p1_q;
  logic signed [11:0] e_p1_q;
  logic [1:0]         lane_p1_q;

  logic               vld_p2_q;
  logic [31:0]        rslt_p2_q;
  logic [4:0]         flag_p2_q;
  logic [1:0]         lane_p2_q;

  logic [31:0]        pack_rslt;
  logic [4:0]         pack_flag;

  assign stall  = vld_p2_q & ~out_ready;
  assign accept = vld_p2_q & out_ready;
  assign issue  = (state_q == ST_RUN) & ~stall;
  assign snap   = (state_q == ST_IDLE) & start;

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          iss_d   = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          iss_d = iss_q + 2'd1;
          if (iss_q == LAST) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (accept && (lane_p2_q == LAST)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (snap) begin
      acc_q[0] <= acc0;
      acc_q[1] <= acc1;
      acc_q[2] <= acc2;
      acc_q[3] <= acc3;
      exp_q[0] <= exp0;
      exp_q[1] <= exp1;
      exp_q[2] <= exp2;
      exp_q[3] <= exp3;
    end
  end

  // Stage 0 -> 1: 33-bit magnitude so that -2^31 normalises like any other value.
  always_comb begin
    acc_s  = acc_q[iss_q];
    exp_s  = exp_q[iss_q];
    mag_s  = acc_s[31] ? (33'd0 - {1'b1, acc_s}) : {1'b0, acc_s};
    lead_s = lead_one(mag_s[31:0]);
    e_s    = $signed({{2{exp_s[9]}}, exp_s}) + E_OFS + $signed({7'b0, lead_s});
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      sign_p1_q <= acc_s[31];
      mag_p1_q  <= mag_s;
      lead_p1_q <= lead_s;
      e_p1_q    <= e_s;
      lane_p1_q <= iss_q;
    end
  end

  // Stage 1 -> 2: pack and register the result.
  fp32_pack u_pack (
    .sign_i (sign_p1_q),
    .mag_i  (mag_p1_q),
    .lead_i (lead_p1_q),
    .e_i    (e_p1_q),
    .rslt_o (pack_rslt),
    .flag_o (pack_flag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      rslt_p2_q <= '0;
      flag_p2_q <= '0;
      lane_p2_q <= '0;
    end else if (!stall) begin
      vld_p1_q <= issue;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        rslt_p2_q <= pack_rslt;
        flag_p2_q <= pack_flag;
        lane_p2_q <= lane_p1_q;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = vld_p2_q;
  assign lane      = lane_p2_q;
  assign rslt      = rslt_p2_q;
  assign flag      = flag_p2_q;

endmodule

// File: tb/tb_acc_drain_fp32.sv
// Directed bench for acc_drain_fp32: table of four-lane drains with
// hand-computed binary32 results, plus backpressure and mid-drain reset.
module tb_acc_drain_fp32;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [31:0] acc0, acc1, acc2, acc3;
  logic [9:0]  exp0, exp1, exp2, exp3;
  logic        busy, out_valid, done;
  logic [1:0]  lane;
  logic [31:0] rslt;
  logic [4:0]  flag;

  int n_cmp, n_fail;

  typedef struct packed {
    logic [3:0][31:0] acc;
    logic [3:0][9:0]  ex;
    logic [3:0][31:0] r;
    logic [3:0][4:0]  f;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];

  acc_drain_fp32 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .acc0      (acc0),
    .acc1      (acc1),
    .acc2      (acc2),
    .acc3      (acc3),
    .exp0      (exp0),
    .exp1      (exp1),
    .exp2      (exp2),
    .exp3      (exp3),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane      (lane),
    .rslt      (rslt),
    .flag      (flag),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic set_lane(input int v, input int l, input logic [31:0] a, input logic [9:0] e,
                          input logic [31:0] r, input logic [4:0] f);
    tbl[v].acc[l] = a;
    tbl[v].ex[l]  = e;
    tbl[v].r[l]   = r;
    tbl[v].f[l]   = f;
  endtask

  task automatic drive(input int v);
    acc0 = tbl[v].acc[0]; acc1 = tbl[v].acc[1]; acc2 = tbl[v].acc[2]; acc3 = tbl[v].acc[3];
    exp0 = tbl[v].ex[0];  exp1 = tbl[v].ex[1];  exp2 = tbl[v].ex[2];  exp3 = tbl[v].ex[3];
  endtask

  task automatic run_vec(input int v);
    int got, cyc, first, dcyc;
    drive(v);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("v%0d_busy_after_start", v), 32'(busy), 32'd1);
    got = 0; cyc = 0; first = -1; dcyc = -1;
    while (got < 4 && cyc < 30) begin
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (done) dcyc = cyc;
        chk($sformatf("v%0d_l%0d_lane", v, got), 32'(lane), 32'(got));
        chk($sformatf("v%0d_l%0d_rslt", v, got), rslt, tbl[v].r[got]);
        chk($sformatf("v%0d_l%0d_flag", v, got), 32'(flag), 32'(tbl[v].f[got]));
        chk($sformatf("v%0d_l%0d_done", v, got), 32'(done), 32'(got == 3));
        got++;
      end
      step();
      cyc++;
    end
    chk($sformatf("v%0d_lanes_delivered", v), 32'(got), 32'd4);
    chk($sformatf("v%0d_first_valid_edge", v), 32'(first), 32'd2);
    chk($sformatf("v%0d_done_edge", v), 32'(dcyc), 32'd5);
    chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
    chk($sformatf("v%0d_valid_end", v), 32'(out_valid), 32'd0);
  endtask

  task automatic backpressure();
    int k, nxt, dones;
    drive(0);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      step();
      k++;
    end
    chk("bp_lane0_lane", 32'(lane), 32'd0);
    chk("bp_lane0_rslt", rslt, tbl[0].r[0]);
    step();
    // Lane 1 now on the output: stall it and try to restart with other data.
    out_ready = 1'b0;
    start = 1'b1;
    drive(1);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("bp_hold%0d_valid", s), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_lane", s), 32'(lane), 32'd1);
      chk($sformatf("bp_hold%0d_rslt", s), rslt, 32'hC000_0000);
      chk($sformatf("bp_hold%0d_flag", s), 32'(flag), 32'd0);
      chk($sformatf("bp_hold%0d_done", s), 32'(done), 32'd0);
      if (s < 3) step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    nxt = 1; dones = 0; k = 0;
    while (nxt < 4 && k < 20) begin
      if (out_valid) begin
        if (done) dones++;
        chk($sformatf("bp_l%0d_lane", nxt), 32'(lane), 32'(nxt));
        chk($sformatf("bp_l%0d_rslt", nxt), rslt, tbl[0].r[nxt]);
        chk($sformatf("bp_l%0d_flag", nxt), 32'(flag), 32'(tbl[0].f[nxt]));
        nxt++;
      end
      step();
      k++;
    end
    chk("bp_lanes_delivered", 32'(nxt), 32'd4);
    chk("bp_done_pulses", 32'(dones), 32'd1);
    chk("bp_busy_end", 32'(busy), 32'd0);
    step(); step();
    chk("bp_no_restart_valid", 32'(out_valid), 32'd0);
    chk("bp_no_restart_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid();
    int k, stray;
    drive(1);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(out_valid && lane == 2'd2) && k < 20) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    chk("rst_lane2_reached", 32'(out_valid && lane == 2'd2), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    chk("rst_async_rslt", rslt, 32'd0);
    chk("rst_async_lane", 32'(lane), 32'd0);
    step(); step();
    reset = 1'b0;
    out_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_valid || busy || done) stray++;
    end
    chk("rst_no_partial_output", 32'(stray), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    acc0 = '0; acc1 = '0; acc2 = '0; acc3 = '0;
    exp0 = '0; exp1 = '0; exp2 = '0; exp3 = '0;

    //           vec lane acc           exp         rslt           flag
    set_lane(0, 0, 32'h4000_0000, 10'd127,   32'h3F80_0000, 5'h00);
    set_lane(0, 1, 32'hC000_0000, 10'd128,   32'hC000_0000, 5'h00);
    set_lane(0, 2, 32'h0000_0000, 10'd127,   32'h0000_0000, 5'h00);
    set_lane(0, 3, 32'h8000_0000, 10'd127,   32'hC000_0000, 5'h00);
    set_lane(1, 0, 32'h4000_0040, 10'd127,   32'h3F80_0000, 5'h01);
    set_lane(1, 1, 32'h4000_00C0, 10'd127,   32'h3F80_0002, 5'h01);
    set_lane(1, 2, 32'h4000_0001, 10'd127,   32'h3F80_0000, 5'h01);
    set_lane(1, 3, 32'h7FFF_FFFF, 10'h1FF,   32'h7F80_0000, 5'h05);
    set_lane(2, 0, 32'h8000_0001, 10'h1FF,   32'hFF80_0000, 5'h05);
    set_lane(2, 1, 32'h4000_0000, 10'd0,     32'h0040_0000, 5'h00);
    set_lane(2, 2, 32'h4000_0001, 10'd0,     32'h0040_0000, 5'h03);
    set_lane(2, 3, 32'h4000_0000, 10'h3D8,   32'h0000_0000, 5'h03);
    set_lane(3, 0, 32'h7FFF_FFFF, 10'd0,     32'h0080_0000, 5'h03);
    set_lane(3, 1, 32'h7FFF_FFFF, 10'd254,   32'h7F80_0000, 5'h05);
    set_lane(3, 2, 32'h7FFF_FFFF, 10'd127,   32'h4000_0000, 5'h01);
    set_lane(3, 3, 32'hFFFF_FFFF, 10'd127,   32'hB080_0000, 5'h00);
    set_lane(4, 0, 32'h0000_0000, 10'h3FB,   32'h0000_0000, 5'h00);
    set_lane(4, 1, 32'h8000_0000, 10'd0,     32'h8080_0000, 5'h00);
    set_lane(4, 2, 32'h4000_0000, 10'h3EA,   32'h0000_0001, 5'h00);
    set_lane(4, 3, 32'h4000_0000, 10'h3E9,   32'h0000_0000, 5'h03);
    set_lane(5, 0, 32'hC000_0000, 10'h3D8,   32'h8000_0000, 5'h03);
    set_lane(5, 1, 32'h0000_0003, 10'd127,   32'h3140_0000, 5'h00);
    set_lane(5, 2, 32'h4000_0000, 10'd255,   32'h7F80_0000, 5'h05);
    set_lane(5, 3, 32'h4000_0000, 10'd254,   32'h7F00_0000, 5'h00);

    step(); step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_lane", 32'(lane), 32'd0);
    chk("reset_rslt", rslt, 32'd0);
    chk("reset_flag", 32'(flag), 32'd0);
    reset = 1'b0;
    step();

    for (int v = 0; v < NV; v++) run_vec(v);
    backpressure();
    reset_mid();
    run_vec(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
